// File: rtl/riscv_dmem_responder_pkg.sv
// Shared address map, status bit layout and decode helper for the
// data-memory responder.
package riscv_mem_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [15:0] OFF_CYCLE  = 16'h0000;
  localparam logic [15:0] OFF_STORES = 16'h0004;
  localparam logic [15:0] OFF_LED    = 16'h0008;
  localparam logic [15:0] OFF_CON    = 16'h000C;

  // Console status word bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_CYCLE,
    REG_STORES,
    REG_LED,
    REG_CON,
    REG_NONE
  } mmio_reg_e;

  // Word-granular decode; the two low address bits never take part.
  function automatic mmio_reg_e decode_addr(input logic [31:0] addr,
                                            input int unsigned words);
    mmio_reg_e r;
    r = REG_NONE;
    if ({2'b00, addr[31:2]} < words) begin
      r = REG_RAM;
    end else if (addr[31:4] == MMIO_BASE[31:4]) begin
      case ({addr[15:2], 2'b00})
        OFF_CYCLE:  r = REG_CYCLE;
        OFF_STORES: r = REG_STORES;
        OFF_LED:    r = REG_LED;
        OFF_CON:    r = REG_CON;
        default:    r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_dmem_responder_if.sv
// Core-to-responder data memory port (M stage load/store).
interface riscv_dmem_responder_if;
  logic [31:0] alu_result_m;
  logic        dmem_write;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;

  modport master (
    output alu_result_m, dmem_write, dmem_write_data,
    input  dmem_read_data
  );

  modport slave (
    input  alu_result_m, dmem_write, dmem_write_data,
    output dmem_read_data
  );
endinterface

// File: rtl/riscv_dmem_responder_console_fifo.sv
// Console byte queue. Pointers carry one extra wrap bit so full and empty
// are distinguishable. rdata is a register that always holds the entry the
// read pointer will address after this edge, so the head is ready with no
// combinational path from the storage array. The caller only pushes when
// the push is acceptable and only pops when not empty.
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, rd_nxt;

  assign rd_nxt = pop ? rd_ptr + ONE : rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count  = wr_ptr - rd_ptr;

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer update and head register refill
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      rd_ptr <= rd_nxt;
      if (push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) rdata <= wdata;
      else                                            rdata <= mem[rd_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO page holding a free-running
// cycle counter, a saturating RAM-store counter, an LED register and a
// console byte output.
// Build option CONSOLE_FIFO_EN: when defined the console is a queued FIFO
// with ready/valid drain and sticky overflow; otherwise a CON write simply
// produces a one-cycle con_valid pulse.
module riscv_dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int    DMEM_WORDS     = 64,
  parameter string DMEM_INIT_FILE = "",
  parameter int    CON_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  riscv_dmem_responder_if.slave        bus,
  output logic [7:0]                   led,
  output logic                         con_valid,
  output logic [7:0]                   con_data,
  input  logic                         con_ready
);
  localparam int IW = $clog2(DMEM_WORDS);

  logic [31:0]   ram [DMEM_WORDS];
  logic [31:0]   cycle_q, stores_q;
  mmio_reg_e     sel;
  logic [IW-1:0] widx;
  logic          wr_ram, wr_led, wr_con;
  logic [2:0]    con_status;
  logic          con_extra;
  logic          unused_ok;

  assign sel    = decode_addr(bus.alu_result_m, DMEM_WORDS);
  assign widx   = bus.alu_result_m[IW+1:2];
  assign wr_ram = bus.dmem_write && (sel == REG_RAM);
  assign wr_led = bus.dmem_write && (sel == REG_LED);
  assign wr_con = bus.dmem_write && (sel == REG_CON);

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) ram[widx] <= bus.dmem_write_data;
  end

  // Cycle counter, store counter and LED register
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= '0;
      stores_q <= '0;
      led      <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_ram && (stores_q != 32'hFFFF_FFFF)) stores_q <= stores_q + 32'd1;
      if (wr_led) led <= bus.dmem_write_data[7:0];
    end
  end

`ifdef CONSOLE_FIFO_EN
  logic                       con_pop, con_push, fifo_full, fifo_empty, ovf_q;
  logic [$clog2(CON_DEPTH):0] con_count;

  // A push into a full queue still lands when a byte leaves the same cycle
  assign con_pop   = con_valid && con_ready;
  assign con_push  = wr_con && (!fifo_full || con_pop);
  assign con_valid = !fifo_empty;

  console_fifo #(.DEPTH(CON_DEPTH), .W(8)) u_con (
    .clk   (clk),
    .reset (reset),
    .push  (con_push),
    .wdata (bus.dmem_write_data[7:0]),
    .pop   (con_pop),
    .rdata (con_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (con_count)
  );

  // Sticky overflow flag for bytes dropped on a full queue
  always_ff @(posedge clk) begin
    if (reset)                                ovf_q <= 1'b0;
    else if (wr_con && fifo_full && !con_pop) ovf_q <= 1'b1;
  end

  // Status word assembly
  always_comb begin
    con_status           = '0;
    con_status[ST_EMPTY] = fifo_empty;
    con_status[ST_FULL]  = fifo_full;
    con_status[ST_OVF]   = ovf_q;
  end

  assign con_extra = ^con_count;
`else
  // One-cycle console strobe per CON write; no back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      con_valid <= 1'b0;
      con_data  <= '0;
    end else begin
      con_valid <= wr_con;
      if (wr_con) con_data <= bus.dmem_write_data[7:0];
    end
  end

  // Status word: always reports an empty queue
  always_comb begin
    con_status           = '0;
    con_status[ST_EMPTY] = 1'b1;
  end

  assign con_extra = con_ready;
`endif

  // Zero-latency read mux; a same-cycle store is not yet visible
  always_comb begin
    bus.dmem_read_data = '0;
    case (sel)
      REG_RAM:    bus.dmem_read_data = ram[widx];
      REG_CYCLE:  bus.dmem_read_data = cycle_q;
      REG_STORES: bus.dmem_read_data = stores_q;
      REG_LED:    bus.dmem_read_data = {24'b0, led};
      REG_CON:    bus.dmem_read_data = {29'b0, con_status};
      default:    bus.dmem_read_data = '0;
    endcase
  end

  assign unused_ok = &{1'b0, bus.alu_result_m[1:0], con_extra};
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized and directed bench for riscv_dmem_responder with a queue-based
// reference model of the memory map and console.
module tb_riscv_dmem_responder;
  localparam int RAM_BYTES = 256;
  localparam int CON_DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led;
  logic       con_valid;
  logic [7:0] con_data;
  logic       con_ready;

  riscv_dmem_responder_if bus();

  riscv_dmem_responder #(.DMEM_WORDS(64), .DMEM_INIT_FILE(""), .CON_DEPTH(CON_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .led       (led),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [64];
  bit          m_known [64];
  int unsigned m_cycle, m_stores;
  logic [7:0]  m_led;
  logic [7:0]  m_q[$];
  bit          m_ovf;
  bit          m_cv;
  logic [7:0]  m_cd;

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [31:0] a;
    bit          push, pop;
    a    = bus.alu_result_m & 32'hFFFF_FFFC;
    push = 0;
    if (bus.dmem_write && a < RAM_BYTES) begin
      m_ram[a[7:2]]   = bus.dmem_write_data;
      m_known[a[7:2]] = 1;
    end
    if (reset) begin
      m_cycle = 0; m_stores = 0; m_led = 0; m_q.delete(); m_ovf = 0; m_cv = 0;
    end else begin
      if (bus.dmem_write) begin
        if (a < RAM_BYTES && m_stores != 32'hFFFF_FFFF) m_stores++;
        if (a == 32'hFFFF_0008) m_led = bus.dmem_write_data[7:0];
        if (a == 32'hFFFF_000C) push = 1;
      end
`ifdef CONSOLE_FIFO_EN
      pop = (m_q.size() > 0) && con_ready;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < CON_DEPTH) m_q.push_back(bus.dmem_write_data[7:0]);
        else                        m_ovf = 1;
      end
`else
      pop  = 0;
      m_cv = push;
      if (push) m_cd = bus.dmem_write_data[7:0];
`endif
      m_cycle++;
    end
  endtask

  // {checkable, value} the model expects on the read port for addr
  function automatic logic [32:0] model_read(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (a < RAM_BYTES) return {m_known[a[7:2]], m_ram[a[7:2]]};
    case (a)
      32'hFFFF_0000: return {1'b1, m_cycle};
      32'hFFFF_0004: return {1'b1, m_stores};
      32'hFFFF_0008: return {1'b1, 24'b0, m_led};
`ifdef CONSOLE_FIFO_EN
      32'hFFFF_000C: return {1'b1, 29'b0, m_ovf, m_q.size() == CON_DEPTH, m_q.size() == 0};
`else
      32'hFFFF_000C: return {1'b1, 32'h1};
`endif
      default:       return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    bus.alu_result_m    = addr;
    bus.dmem_write      = wr;
    bus.dmem_write_data = data;
  endtask

  task automatic test_reset();
    drive(32'h0, 0, 32'h0);
    con_ready = 0;
    reset = 1;
    repeat (3) tick();
    reset = 0;
    drive(32'hFFFF_0000, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %h want %h", bus.dmem_read_data, 32'h0); end
    drive(32'hFFFF_0004, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_stores: got %h want %h", bus.dmem_read_data, 32'h0); end
    n_checks++; if (led !== 8'h0) begin n_fail++; $display("FAIL reset_led: got %h want %h", led, 8'h0); end
    n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL reset_con_valid: got %b want 0", con_valid); end
    drive(32'hFFFF_000C, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want %h", bus.dmem_read_data, 32'h1); end
    repeat (5) tick();
    drive(32'hFFFF_0000, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h5) begin n_fail++; $display("FAIL cycle_5: got %h want %h", bus.dmem_read_data, 32'h5); end
  endtask

  task automatic test_ram();
    drive(32'h10, 1, 32'h1234_5678); tick();
    drive(32'h10, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_load: got %h want %h", bus.dmem_read_data, 32'h1234_5678); end
    drive(32'h13, 1, 32'hAAAA_AAAA); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_same_cycle_old: got %h want %h", bus.dmem_read_data, 32'h1234_5678); end
    tick();
    drive(32'h10, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL ram_after_store: got %h want %h", bus.dmem_read_data, 32'hAAAA_AAAA); end
    drive(32'hFFFF_0004, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== m_stores) begin n_fail++; $display("FAIL stores_count: got %h want %h", bus.dmem_read_data, m_stores); end
  endtask

  task automatic test_led();
    logic [31:0] exp_st;
    drive(32'hFFFF_0008, 1, 32'hFFFF_FFA5); tick();
    drive(32'hFFFF_0008, 0, 32'h0); #1;
    n_checks++; if (led !== 8'hA5) begin n_fail++; $display("FAIL led_port: got %h want %h", led, 8'hA5); end
    n_checks++; if (bus.dmem_read_data !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_read: got %h want %h", bus.dmem_read_data, 32'hA5); end
    exp_st = m_stores;
    drive(32'hFFFF_0000, 1, 32'h0000_0000); tick();
    drive(32'hFFFF_0000, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== m_cycle || m_cycle < 3) begin n_fail++; $display("FAIL cycle_ro: got %h want %h", bus.dmem_read_data, m_cycle); end
    drive(32'hFFFF_0004, 1, 32'hDEAD_BEEF); tick();
    drive(32'hFFFF_0004, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== exp_st) begin n_fail++; $display("FAIL stores_ro: got %h want %h", bus.dmem_read_data, exp_st); end
  endtask

  task automatic test_unmapped();
    drive(32'h8000_0000, 1, 32'h5555_5555); tick();
    drive(32'h8000_0000, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", bus.dmem_read_data, 32'h0); end
    drive(32'hFFFF_0010, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_mmio: got %h want %h", bus.dmem_read_data, 32'h0); end
  endtask

`ifdef CONSOLE_FIFO_EN
  task automatic test_con_overflow();
    logic [7:0] got[$];
    reset = 1; con_ready = 0; drive(32'h0, 0, 32'h0); tick(); reset = 0;
    for (int i = 0; i < 9; i++) begin
      drive(32'hFFFF_000C, 1, {$urandom, 8'h41 + 8'(i)} >> 0 & 32'hFFFF_FF00 | 32'(8'h41 + 8'(i)));
      tick();
    end
    drive(32'hFFFF_000C, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h6) begin n_fail++; $display("FAIL ovf_status: got %h want %h", bus.dmem_read_data, 32'h6); end
    con_ready = 1;
    for (int c = 0; c < 20 && got.size() < 9; c++) begin
      #1;
      if (con_valid) got.push_back(con_data);
      tick();
    end
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", got.size(), 8); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++; if (got[i] !== 8'h41 + 8'(i)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, got[i], 8'h41 + 8'(i)); end
    end
    #1;
    n_checks++; if (bus.dmem_read_data !== 32'h5) begin n_fail++; $display("FAIL drained_status: got %h want %h", bus.dmem_read_data, 32'h5); end
    con_ready = 0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] got[$];
    reset = 1; con_ready = 0; drive(32'h0, 0, 32'h0); tick(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      drive(32'hFFFF_000C, 1, 32'(8'h50 + 8'(i))); tick();
    end
    drive(32'hFFFF_000C, 1, 32'h0000_015A);
    con_ready = 1; #1;
    n_checks++; if (con_data !== 8'h50 || con_valid !== 1'b1) begin n_fail++; $display("FAIL full_head: got %h/%b want 50/1", con_data, con_valid); end
    tick();
    drive(32'hFFFF_000C, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data[2] !== 1'b0 || bus.dmem_read_data[1] !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_status: got %h want ovf=0 full=1", bus.dmem_read_data); end
    for (int c = 0; c < 20 && got.size() < 9; c++) begin
      #1;
      if (con_valid) got.push_back(con_data);
      tick();
    end
    n_checks++; if (got.size() != 8 || got[got.size()-1] !== 8'h5A) begin n_fail++; $display("FAIL last_popped: got %0d bytes last %h want 8 bytes last 5a", got.size(), got.size() ? got[got.size()-1] : 8'h0); end
    #1;
    n_checks++; if (bus.dmem_read_data !== 32'h1) begin n_fail++; $display("FAIL pushpop_drained_status: got %h want %h", bus.dmem_read_data, 32'h1); end
    con_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hFFFF_000C, 1, 32'(8'h60 + 8'(i))); tick();
    end
    drive(32'hFFFF_000C, 0, 32'h0); #1;
    n_checks++; if (con_valid !== 1'b1 || bus.dmem_read_data !== 32'h0) begin n_fail++; $display("FAIL queued_3: got valid=%b status=%h want 1/0", con_valid, bus.dmem_read_data); end
    reset = 1; tick(); #1;
    n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_valid: got %b want 0", con_valid); end
    n_checks++; if (bus.dmem_read_data !== 32'h1) begin n_fail++; $display("FAIL reset_flush_status: got %h want %h", bus.dmem_read_data, 32'h1); end
    reset = 0;
  endtask
`else
  task automatic test_con_pulse();
    con_ready = 0;
    drive(32'hFFFF_000C, 1, 32'h0000_0021); tick();
    drive(32'h0, 0, 32'h0); #1;
    n_checks++; if (con_valid !== 1'b1 || con_data !== 8'h21) begin n_fail++; $display("FAIL con_pulse_high: got %b/%h want 1/21", con_valid, con_data); end
    tick(); #1;
    n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL con_pulse_low: got %b want 0", con_valid); end
    drive(32'hFFFF_000C, 0, 32'h0); #1;
    n_checks++; if (bus.dmem_read_data !== 32'h1) begin n_fail++; $display("FAIL con_status_fixed: got %h want %h", bus.dmem_read_data, 32'h1); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] addr;
    logic [32:0] exp;
    logic [5:0]  w;
    logic [1:0]  lo;
    for (int n = 0; n < 400; n++) begin
      w  = 6'($urandom_range(0, 63));
      lo = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: addr = {24'h0, w, lo};
        5:             addr = {30'h3FFF_C000, lo};
        6:             addr = {30'h3FFF_C001, lo};
        7:             addr = {30'h3FFF_C002, lo};
        8:             addr = {30'h3FFF_C003, lo};
        default: begin
          case ($urandom_range(0, 3))
            0:       addr = 32'h8000_0000;
            1:       addr = 32'hFFFF_0010;
            2:       addr = {22'h0, 2'b01, w, lo};
            default: addr = 32'hFFFE_0008;
          endcase
        end
      endcase
      drive(addr, ($urandom_range(0, 9) < 4), $urandom);
      con_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp = model_read(addr);
      if (exp[32]) begin
        n_checks++; if (bus.dmem_read_data !== exp[31:0]) begin n_fail++; $display("FAIL rand_read @%h: got %h want %h", addr, bus.dmem_read_data, exp[31:0]); end
      end
      n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led: got %h want %h", led, m_led); end
`ifdef CONSOLE_FIFO_EN
      n_checks++; if (con_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rand_con_valid: got %b want %b", con_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_checks++; if (con_data !== m_q[0]) begin n_fail++; $display("FAIL rand_con_data: got %h want %h", con_data, m_q[0]); end
      end
`else
      n_checks++; if (con_valid !== m_cv) begin n_fail++; $display("FAIL rand_con_valid: got %b want %b", con_valid, m_cv); end
      if (m_cv) begin
        n_checks++; if (con_data !== m_cd) begin n_fail++; $display("FAIL rand_con_data: got %h want %h", con_data, m_cd); end
      end
`endif
      tick();
    end
    drive(32'h0, 0, 32'h0);
    con_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_known[i] = 0;
    m_cycle = 0; m_stores = 0; m_led = 0; m_ovf = 0; m_cv = 0; m_cd = 0;
    reset = 1; con_ready = 0;
    drive(32'h0, 0, 32'h0);
    test_reset();
    test_ram();
    test_led();
    test_unmapped();
`ifdef CONSOLE_FIFO_EN
    test_con_overflow();
    test_full_push_pop();
`else
    test_con_pulse();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
